// File: rtl/note_player_ctrl.sv
// Note sequencer for one sine_reader voice: fetches step_size from the frequency ROM,
// counts the note's beats, and gates sample requests/samples between sine_reader and codec.
module note_player_ctrl #(
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int STEP_W   = 20,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                load_new_note,
  input  logic [NOTE_W-1:0]   note_to_load,
  input  logic [DUR_W-1:0]    duration_to_load,
  input  logic                beat,
  input  logic                generate_next_sample,
  output logic [NOTE_W-1:0]   rom_addr,
  input  logic [STEP_W-1:0]   rom_data,
  output logic [STEP_W-1:0]   step_size,
  output logic                sr_generate_next,
  input  logic                sr_sample_ready,
  input  logic [SAMPLE_W-1:0] sr_sample,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                new_sample_ready,
  output logic                note_busy,
  output logic                done_with_note
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [DUR_W-1:0] DUR_ZERO = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};

  logic [2:0]          state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [STEP_W-1:0]   step_size_q, step_size_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                nsr_q, nsr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Note sequencing: latch, ROM fetch, step load and beat counting.
  always_comb begin
    state_d     = state_q;
    note_d      = note_q;
    dur_d       = dur_q;
    dur_cnt_d   = dur_cnt_q;
    step_size_d = step_size_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_new_note) begin
          note_d  = note_to_load;
          dur_d   = duration_to_load;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        step_size_d = (note_q == {NOTE_W{1'b0}}) ? {STEP_W{1'b0}} : rom_data;
        dur_cnt_d   = dur_q;
        if (dur_q == DUR_ZERO) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // The nonzero guard keeps the counter from ever wrapping below zero.
        if (play_enable && beat && (dur_cnt_q != DUR_ZERO)) begin
          dur_cnt_d = dur_cnt_q - DUR_ONE;
          if (dur_cnt_q == DUR_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PLAY;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_comb begin
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_FETCH) || (state_d == ST_LATCH) || (state_d == ST_PLAY);
  end

  // Sample path: rests, pauses and idle time deliver silence.
  always_comb begin
    if (sr_sample_ready) begin
      nsr_d    = 1'b1;
      sample_d = ((state_q == ST_PLAY) && (note_q != {NOTE_W{1'b0}})) ? sr_sample
                                                                       : {SAMPLE_W{1'b0}};
    end else begin
      nsr_d    = 1'b0;
      sample_d = sample_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      note_q      <= {NOTE_W{1'b0}};
      dur_q       <= DUR_ZERO;
      dur_cnt_q   <= DUR_ZERO;
      step_size_q <= {STEP_W{1'b0}};
      sample_q    <= {SAMPLE_W{1'b0}};
      nsr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      dur_cnt_q   <= dur_cnt_d;
      step_size_q <= step_size_d;
      sample_q    <= sample_d;
      nsr_q       <= nsr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr         = note_q;
  assign step_size        = step_size_q;
  assign sr_generate_next = generate_next_sample & play_enable;
  assign sample_out       = sample_q;
  assign new_sample_ready = nsr_q;
  assign note_busy        = busy_q;
  assign done_with_note   = done_q;

endmodule

// File: tb/tb_note_player_ctrl.sv
// Directed bench for note_player_ctrl: a note-lifetime model (cycles since load, beats left)
// is compared with the DUT every cycle, plus hand-computed literal checks at key points.
module tb_note_player_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        load_new_note;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        beat;
  logic        generate_next_sample;
  logic [5:0]  rom_addr;
  logic [19:0] rom_data;
  logic [19:0] step_size;
  logic        sr_generate_next;
  logic        sr_sample_ready;
  logic [15:0] sr_sample;
  logic [15:0] sample_out;
  logic        new_sample_ready;
  logic        note_busy;
  logic        done_with_note;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  note_player_ctrl dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
    .note_to_load(note_to_load), .duration_to_load(duration_to_load), .beat(beat),
    .generate_next_sample(generate_next_sample), .rom_addr(rom_addr), .rom_data(rom_data),
    .step_size(step_size), .sr_generate_next(sr_generate_next),
    .sr_sample_ready(sr_sample_ready), .sr_sample(sr_sample), .sample_out(sample_out),
    .new_sample_ready(new_sample_ready), .note_busy(note_busy),
    .done_with_note(done_with_note)
  );

  always #5 clk = ~clk;

  // Frequency ROM: step = note*1000, one cycle of read latency.
  always @(posedge clk) rom_data <= {14'd0, rom_addr} * 20'd1000;

  // Minimal sine_reader stand-in: answers each request one cycle later with a new sample.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_sample_ready <= 1'b0;
      sr_sample       <= 16'h0100;
    end else begin
      sr_sample_ready <= sr_generate_next;
      if (sr_generate_next) sr_sample <= sr_sample + 16'd123;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a note is described by its age since acceptance (1 fetch, 2 latch, 3 playing)
  // and the beats it still owes.
  int m_age = 0, m_left = 0, m_note = 0, m_dur = 0, m_step = 0, m_sample = 0;
  bit m_nsr = 1'b0, m_done = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_age = 0; m_left = 0; m_note = 0; m_dur = 0; m_step = 0; m_sample = 0;
        m_nsr = 1'b0; m_done = 1'b0;
      end else begin
        bit playing, busy_old;
        playing  = (m_age == 3);
        busy_old = (m_age != 0);
        m_nsr = sr_sample_ready;
        if (sr_sample_ready) m_sample = (playing && m_note != 0) ? int'(sr_sample) : 0;
        m_done = 1'b0;
        if (m_age == 1) begin
          m_age = 2;
        end else if (m_age == 2) begin
          m_step = m_note * 1000;
          m_left = m_dur;
          if (m_dur == 0) begin m_done = 1'b1; m_age = 0; end
          else m_age = 3;
        end else if (m_age == 3 && play_enable && beat) begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_done = 1'b1; m_age = 0; end
        end
        if (load_new_note && !busy_old) begin
          m_note = int'(note_to_load);
          m_dur  = int'(duration_to_load);
          m_age  = 1;
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("step_size", 32'(step_size), 32'(m_step));
      chk("sample_out", 32'(sample_out), 32'(m_sample));
      chk("new_sample_ready", 32'(new_sample_ready), 32'(m_nsr));
      chk("note_busy", 32'(note_busy), 32'(m_age != 0));
      chk("done_with_note", 32'(done_with_note), 32'(m_done));
      chk("rom_addr", 32'(rom_addr), 32'(m_note));
      chk("sr_generate_next", 32'(sr_generate_next),
          32'(generate_next_sample & play_enable));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat_pulse();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    note_to_load = n;
    duration_to_load = d;
    load_new_note = 1'b1;
    tick();
    load_new_note = 1'b0;
  endtask

  initial begin
    reset = 1'b1; play_enable = 1'b0; load_new_note = 1'b0; note_to_load = 6'd0;
    duration_to_load = 6'd0; beat = 1'b0; generate_next_sample = 1'b0;
    #1 reset = 1'b0;
    chk_on = 1'b1;
    tick(); tick();
    chk("rst_step", 32'(step_size), 32'd0);
    chk("rst_busy", 32'(note_busy), 32'd0);
    chk("rst_done", 32'(done_with_note), 32'd0);
    chk("rst_sample", 32'(sample_out), 32'd0);
    chk("rst_nsr", 32'(new_sample_ready), 32'd0);
    reset = 1'b1;
    tick();

    // Note 5 for 3 beats.
    load(6'd5, 6'd3);
    chk("busy_cycle1", 32'(note_busy), 32'd1);
    tick();
    chk("step_cycle2", 32'(step_size), 32'd0);
    tick();
    chk("step_cycle3", 32'(step_size), 32'd5000);
    play_enable = 1'b1;
    for (int b = 0; b < 3; b++) begin
      repeat (9) begin generate_next_sample = ~generate_next_sample; tick(); end
      beat_pulse();
      if (b < 2) chk("done_early", 32'(done_with_note), 32'd0);
    end
    chk("done_after_beat3", 32'(done_with_note), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done_with_note), 32'd0);
    generate_next_sample = 1'b0;

    // Rest for 2 beats.
    load(6'd0, 6'd2);
    tick(); tick();
    chk("rest_step", 32'(step_size), 32'd0);
    generate_next_sample = 1'b1;
    repeat (3) tick();
    beat_pulse();
    repeat (3) tick();
    chk("rest_sample", 32'(sample_out), 32'd0);
    beat_pulse();
    chk("rest_done", 32'(done_with_note), 32'd1);

    // Pause mid-note: only play_enable=1 beats count.
    load(6'd7, 6'd3);
    tick(); tick();
    repeat (3) tick();
    beat_pulse();
    play_enable = 1'b0;
    repeat (5) begin tick(); tick(); beat_pulse(); end
    chk("pause_no_done", 32'(done_with_note), 32'd0);
    chk("pause_gen_gated", 32'(sr_generate_next), 32'd0);
    play_enable = 1'b1;
    tick();
    beat_pulse();
    chk("pause_beat2", 32'(done_with_note), 32'd0);
    tick();
    beat_pulse();
    chk("pause_done", 32'(done_with_note), 32'd1);
    generate_next_sample = 1'b0;
    tick();

    // Load during PLAY is ignored; load in the DONE cycle is accepted.
    load(6'd9, 6'd1);
    tick(); tick();
    load(6'd3, 6'd2);
    chk("ignored_load", 32'(rom_addr), 32'd9);
    beat_pulse();
    chk("short_done", 32'(done_with_note), 32'd1);
    load(6'd4, 6'd2);
    chk("done_load_busy", 32'(note_busy), 32'd1);
    chk("done_load_addr", 32'(rom_addr), 32'd4);
    tick(); tick();
    chk("done_load_step", 32'(step_size), 32'd4000);
    beat_pulse(); tick(); beat_pulse();
    chk("n4_done", 32'(done_with_note), 32'd1);
    tick();

    // Zero duration: done at cycle 3, never plays.
    load(6'd6, 6'd0);
    tick(); tick();
    chk("dur0_done", 32'(done_with_note), 32'd1);
    chk("dur0_step", 32'(step_size), 32'd6000);
    chk("dur0_busy", 32'(note_busy), 32'd0);
    tick();

    // Maximum duration, one beat per cycle.
    load(6'd1, 6'd63);
    tick(); tick();
    beat = 1'b1;
    repeat (62) tick();
    chk("max_62", 32'(done_with_note), 32'd0);
    tick();
    beat = 1'b0;
    chk("max_done", 32'(done_with_note), 32'd1);
    tick();

    // Asynchronous reset mid-PLAY, between clock edges.
    load(6'd2, 6'd5);
    tick(); tick();
    beat_pulse();
    tick();
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_step", 32'(step_size), 32'd0);
    chk("async_busy", 32'(note_busy), 32'd0);
    chk("async_done", 32'(done_with_note), 32'd0);
    chk("async_addr", 32'(rom_addr), 32'd0);
    tick(); tick();
    chk("async_no_done", 32'(done_with_note), 32'd0);
    reset = 1'b1;
    tick();
    load(6'd8, 6'd1);
    tick(); tick();
    chk("post_rst_step", 32'(step_size), 32'd8000);
    beat_pulse();
    chk("post_rst_done", 32'(done_with_note), 32'd1);
    tick(); tick();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
